// File: rtl/shift_reg_frame_ctrl_pkg.sv
// Shared types for the BCH front-end frame fill controller.
// State encoding and fill-counter width helper.
package shift_reg_frame_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FILL  = 3'd2,
      S_FLUSH = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   function automatic int cnt_width(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/shift_reg_frame_ctrl.sv
// Fills one shift_reg instance with exactly one frame of symbols
// and hands the full frame downstream over a valid/ready pair.
module shift_reg_frame_ctrl
   import shift_reg_frame_ctrl_pkg::*;
#(
   parameter int SHIFT_LEN = 16,
   parameter int BIT_WIDTH = 4,
   parameter int CNT_W     = cnt_width(SHIFT_LEN)
) (
   input  logic                 clk,
   input  logic                 in_ctr_Arst,
   input  logic                 in_ctr_start,
   input  logic                 in_ctr_abort,
   input  logic                 in_valid,
   output logic                 out_ready,
   input  logic [BIT_WIDTH-1:0] in_data,
   output logic                 out_sr_Srst,
   output logic                 out_sr_en,
   output logic [BIT_WIDTH-1:0] out_sr_data,
   output logic                 out_frame_valid,
   input  logic                 in_frame_ready,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_busy
);

   state_t state, state_nx;

   logic                 abort;
   logic                 accept;
   logic                 last;
   logic                 srst_nx;
   logic                 en_nx;
   logic [BIT_WIDTH-1:0] data_nx;
   logic                 fv_nx;
   logic [CNT_W-1:0]     cnt_nx;

   assign out_ready = (state == S_FILL);
   assign out_busy  = (state != S_IDLE);
   assign abort     = in_ctr_abort & (state != S_IDLE);
   assign accept    = in_valid & out_ready;
   assign last      = (out_count == CNT_W'(SHIFT_LEN - 1));

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (in_ctr_start) state_nx = S_CLEAR;
         S_CLEAR: state_nx = S_FILL;
         S_FILL:  if (accept && last) state_nx = S_FLUSH;
         S_FLUSH: state_nx = S_HOLD;
         S_HOLD: begin
            if (in_frame_ready)
               state_nx = in_ctr_start ? S_CLEAR : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   // Abort wins over everything: the beat it races with is never written.
   always_comb begin
      srst_nx = (state_nx == S_CLEAR) | abort;
      en_nx   = accept & ~abort;
      data_nx = en_nx ? in_data : out_sr_data;
      fv_nx   = out_frame_valid;
      cnt_nx  = out_count;
      if (state == S_CLEAR)
         cnt_nx = '0;
      else if (accept)
         cnt_nx = out_count + CNT_W'(1);
      if (state == S_FLUSH)
         fv_nx = 1'b1;
      else if (state == S_HOLD && in_frame_ready)
         fv_nx = 1'b0;
      if (abort) begin
         cnt_nx = '0;
         fv_nx  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge in_ctr_Arst) begin
      if (in_ctr_Arst) begin
         state           <= S_IDLE;
         out_sr_Srst     <= 1'b0;
         out_sr_en       <= 1'b0;
         out_sr_data     <= '0;
         out_frame_valid <= 1'b0;
         out_count       <= '0;
      end else begin
         state           <= state_nx;
         out_sr_Srst     <= srst_nx;
         out_sr_en       <= en_nx;
         out_sr_data     <= data_nx;
         out_frame_valid <= fv_nx;
         out_count       <= cnt_nx;
      end
   end

endmodule
